// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO write-pointer block: producer request,
// synchronised read pointer in, RAM write controls and status out.
interface fifo_wptr_full_if #(
  parameter int ADDR_W = 4
);
  logic              w_en;
  logic [ADDR_W:0]   rptr_gray_sync;
  logic              clr_overflow;
  logic              wr_accept;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;

  modport master (
    output w_en, rptr_gray_sync, clr_overflow,
    input  wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  w_en, rptr_gray_sync, clr_overflow,
    output wr_accept, waddr, wptr_gray, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-domain pointer/status: 0-cycle accept, status registered 1 edge later.
// Backpressure: writes rejected while registered full is high; overflow sticks on such attempts.
module fifo_wptr_full #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = (1 << ADDR_W) - 2
) (
  input  logic                Clk,
  input  logic                reset,
  fifo_wptr_full_if.slave     wif
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_cmp;

  always_comb begin
    accept    = wif.w_en & ~full_q;
    wbin_d    = wbin_q + {{ADDR_W{1'b0}}, accept};
    wgray_d   = wbin_d ^ (wbin_d >> 1);

    // Gray-to-binary as an XOR prefix running down from the MSB
    rbin_sync         = '0;
    rbin_sync[PW-1]   = wif.rptr_gray_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ wif.rptr_gray_sync[i];
    end

    full_cmp  = {~wif.rptr_gray_sync[ADDR_W:ADDR_W-1], wif.rptr_gray_sync[ADDR_W-2:0]};
    full_d    = (wgray_d == full_cmp);
    level_d   = wbin_d - rbin_sync;
    af_d      = (level_d >= AF_LVL);
    // Set takes priority over clear so an attempt in the clearing cycle is not lost
    ovf_d     = (wif.w_en & full_q) | (ovf_q & ~wif.clr_overflow);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wif.wr_accept   = accept;
  assign wif.waddr       = wbin_q[ADDR_W-1:0];
  assign wif.wptr_gray   = wgray_q;
  assign wif.full        = full_q;
  assign wif.almost_full = af_q;
  assign wif.wr_level    = level_q;
  assign wif.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_W=4, AF_THRESH=14): vector table plus
// hand-written wrap and reset sequences.
module tb_fifo_wptr_full;
  localparam int AW = 4;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  fifo_wptr_full_if #(.ADDR_W(AW)) wif ();

  fifo_wptr_full #(.ADDR_W(AW), .AF_THRESH(14)) dut (
    .Clk   (Clk),
    .reset (reset),
    .wif   (wif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       w_en;
    logic [4:0] rg;
    logic       clr;
    logic       acc;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
    logic [3:0] waddr;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  logic [4:0] g16 [16];

  function automatic vec_t mk(logic w, logic [4:0] rg, logic clr, logic acc,
                              logic [4:0] gray, logic full, logic af,
                              logic [4:0] lvl, logic ovf, logic [3:0] wa);
    vec_t v;
    v.w_en = w; v.rg = rg; v.clr = clr; v.acc = acc; v.gray = gray;
    v.full = full; v.af = af; v.lvl = lvl; v.ovf = ovf; v.waddr = wa;
    return v;
  endfunction

  function automatic logic [4:0] b2g(logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(logic rst, logic w, logic [4:0] rg, logic clr);
    @(negedge Clk);
    reset              = rst;
    wif.w_en           = w;
    wif.rptr_gray_sync = rg;
    wif.clr_overflow   = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_regs(string tag, logic [4:0] gray, logic full, logic af,
                            logic [4:0] lvl, logic ovf, logic [3:0] wa);
    chk({tag, ".wptr_gray"},   32'(wif.wptr_gray),   32'(gray));
    chk({tag, ".full"},        32'(wif.full),        32'(full));
    chk({tag, ".almost_full"}, 32'(wif.almost_full), 32'(af));
    chk({tag, ".wr_level"},    32'(wif.wr_level),    32'(lvl));
    chk({tag, ".overflow"},    32'(wif.overflow),    32'(ovf));
    chk({tag, ".waddr"},       32'(wif.waddr),       32'(wa));
  endtask

  initial begin
    logic [4:0] wb;
    logic [4:0] prev_act;
    logic [4:0] nxt;

    g16 = '{5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04, 5'h0C,
            5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08, 5'h18};

    // First edge after release with no write: everything still zero
    vecs[0] = mk(0, 5'h00, 0, 0, 5'h00, 0, 0, 5'd0, 0, 4'd0);
    // 16 back-to-back writes against an empty read side
    for (int k = 1; k <= 16; k++) begin
      vecs[k] = mk(1, 5'h00, 0, 1, g16[k-1], (k == 16), (k >= 14),
                   5'(k), 0, 4'(k % 16));
    end
    // Write while full: rejected, overflow set and sticky
    vecs[17] = mk(1, 5'h00, 0, 0, 5'h18, 1, 1, 5'd16, 1, 4'd0);
    vecs[18] = mk(0, 5'h00, 0, 0, 5'h18, 1, 1, 5'd16, 1, 4'd0);
    // Clear in the same cycle as another attempt: set wins
    vecs[19] = mk(1, 5'h00, 1, 0, 5'h18, 1, 1, 5'd16, 1, 4'd0);
    vecs[20] = mk(0, 5'h00, 1, 0, 5'h18, 1, 1, 5'd16, 0, 4'd0);
    // Read pointer advances by one: full drops, level 15
    vecs[21] = mk(0, 5'h01, 0, 0, 5'h18, 0, 1, 5'd15, 0, 4'd0);
    vecs[22] = mk(1, 5'h01, 0, 1, 5'h19, 1, 1, 5'd16, 0, 4'd1);
    // Write and read advance together while full: write rejected, full drops
    vecs[23] = mk(1, 5'h03, 0, 0, 5'h19, 0, 1, 5'd15, 1, 4'd1);
    vecs[24] = mk(0, 5'h03, 1, 0, 5'h19, 0, 1, 5'd15, 0, 4'd1);

    reset              = 1'b1;
    wif.w_en           = 1'b1;
    wif.rptr_gray_sync = 5'h00;
    wif.clr_overflow   = 1'b0;

    // Reset held with w_en high: pointer must not move
    for (int i = 0; i < 3; i++) begin
      tick();
      check_regs($sformatf("rst%0d", i), 5'h00, 0, 0, 5'd0, 0, 4'd0);
    end

    for (int i = 0; i < NV; i++) begin
      apply(0, vecs[i].w_en, vecs[i].rg, vecs[i].clr);
      chk($sformatf("v%0d.wr_accept", i), 32'(wif.wr_accept), 32'(vecs[i].acc));
      tick();
      check_regs($sformatf("v%0d", i), vecs[i].gray, vecs[i].full, vecs[i].af,
                 vecs[i].lvl, vecs[i].ovf, vecs[i].waddr);
    end

    // Wrap through 31 -> 0 with the read side trailing by two entries
    wb       = 5'd17;
    prev_act = 5'h19;
    for (int i = 0; i < 16; i++) begin
      apply(0, 1, b2g(wb - 5'd2), 0);
      chk($sformatf("wrap%0d.wr_accept", i), 32'(wif.wr_accept), 32'd1);
      tick();
      nxt = wb + 5'd1;
      chk($sformatf("wrap%0d.wptr_gray", i), 32'(wif.wptr_gray), 32'(b2g(nxt)));
      chk($sformatf("wrap%0d.onebit", i), 32'($countones(wif.wptr_gray ^ prev_act)), 32'd1);
      chk($sformatf("wrap%0d.wr_level", i), 32'(wif.wr_level), 32'd3);
      chk($sformatf("wrap%0d.full", i), 32'(wif.full), 32'd0);
      chk($sformatf("wrap%0d.almost_full", i), 32'(wif.almost_full), 32'd0);
      if (nxt == 5'd31) chk("wrap.gray31", 32'(wif.wptr_gray), 32'h10);
      if (nxt == 5'd0)  chk("wrap.gray0",  32'(wif.wptr_gray), 32'h00);
      prev_act = wif.wptr_gray;
      wb       = nxt;
    end

    // Fill to 10 entries with the read pointer parked at 30 (wbin 1 -> 8)
    for (int i = 0; i < 7; i++) begin
      apply(0, 1, 5'h11, 0);
      tick();
      chk($sformatf("fill%0d.wr_level", i), 32'(wif.wr_level), 32'(4 + i));
    end
    chk("fill.waddr", 32'(wif.waddr), 32'd8);

    // Single-cycle reset with writes still requested
    apply(1, 1, 5'h11, 0);
    tick();
    check_regs("rst_mid", 5'h00, 0, 0, 5'd0, 0, 4'd0);
    apply(0, 0, 5'h00, 0);
    tick();
    check_regs("post_rst", 5'h00, 0, 0, 5'd0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
